// File: rtl/playsongs_seq.sv
// rtl/playsongs_seq.sv - ROM-driven buzzer score sequencer with tempo, octave bit and articulation gap.
// Define SONG_LOOP_EN to replay the song from its base after the end marker instead of returning to idle.
module playsongs_seq #(
    parameter int DIV_W       = 17,
    parameter int ADDR_W      = 8,
    parameter int SONG_W      = 2,
    parameter int BEAT_CYCLES = 12500000,
    parameter int BEAT_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [SONG_W-1:0] song_sel,
    input  logic [1:0]        tempo,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              buzzer,
    output logic              busy,
    output logic              done
);
    localparam int OFF_W = ADDR_W - SONG_W;
    // One extra bit so BEAT_CYCLES == 2**BEAT_W still represents a full beat length.
    localparam int BL_W = BEAT_W + 1;
    localparam logic [BL_W-1:0] BEAT_FULL = BL_W'(BEAT_CYCLES);
    localparam logic [3:0] PITCH_END = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_END
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]        tempo_q, tempo_d;
    logic              rest_q, rest_d;
    logic [3:0]        dur_q, dur_d;
    logic [3:0]        dur_cnt_q, dur_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt0_q, cnt0_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              buzzer_q, buzzer_d;

    logic [BL_W-1:0] beat_raw, beat_len, beat_last, gap_start, beat_pos;
    logic            last_beat, beat_end, note_end, in_gap, tone_hi;

    // Bit 3 of the pitch code selects the upper octave; bits 2:0 pick the note (0 = rest).
    function automatic logic [DIV_W-1:0] note_div(input logic [3:0] code);
        logic [DIV_W-1:0] d;
        case (code[2:0])
            3'd1:    d = DIV_W'(45871);
            3'd2:    d = DIV_W'(40872);
            3'd3:    d = DIV_W'(36407);
            3'd4:    d = DIV_W'(34364);
            3'd5:    d = DIV_W'(30612);
            3'd6:    d = DIV_W'(27272);
            3'd7:    d = DIV_W'(24301);
            default: d = DIV_W'(2);
        endcase
        if (code[3]) begin
            d = d >> 1;
        end
        return d;
    endfunction

    always_comb begin
        beat_raw  = BEAT_FULL >> tempo_q;
        beat_len  = (beat_raw == '0) ? BL_W'(1) : beat_raw;
        beat_last = beat_len - BL_W'(1);
        gap_start = beat_len - (beat_len >> 3);
        beat_pos  = {1'b0, beat_cnt_q};
        last_beat = (dur_cnt_q == dur_q);
        beat_end  = (beat_pos == beat_last);
        note_end  = last_beat && beat_end;
        in_gap    = last_beat && (beat_pos >= gap_start);
        tone_hi   = (cnt0_q >= (div_q >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: state_d = (rom_data[7:4] == PITCH_END) ? S_END : S_PLAY;
                S_PLAY: begin
                    if (note_end) begin
                        state_d = S_FETCH;
                    end
                end
`ifdef SONG_LOOP_EN
                S_END:    state_d = S_FETCH;
`else
                S_END:    state_d = S_IDLE;
`endif
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_END);
        rom_addr = rom_addr_q;
        buzzer = buzzer_q;
        // Looking at state_d keeps the pin low on the cycle a note is left or aborted.
        buzzer_d = (state_q == S_PLAY) && (state_d == S_PLAY) && !rest_q && !in_gap && tone_hi;
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        tempo_d    = tempo_q;
        rest_d     = rest_q;
        dur_d      = dur_q;
        dur_cnt_d  = dur_cnt_q;
        div_d      = div_q;
        cnt0_d     = cnt0_q;
        beat_cnt_d = beat_cnt_q;
        if (start && !stop) begin
            tempo_d    = tempo;
            rom_addr_d = {song_sel, {OFF_W{1'b0}}};
        end else if (!stop) begin
            case (state_q)
                S_DECODE: begin
                    rest_d     = (rom_data[6:4] == 3'd0);
                    dur_d      = rom_data[3:0];
                    div_d      = note_div(rom_data[7:4]);
                    cnt0_d     = '0;
                    beat_cnt_d = '0;
                    dur_cnt_d  = '0;
                end
                S_PLAY: begin
                    cnt0_d = (cnt0_q == div_q - DIV_W'(1)) ? '0 : cnt0_q + DIV_W'(1);
                    if (beat_end) begin
                        beat_cnt_d = '0;
                        dur_cnt_d  = dur_cnt_q + 4'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                    // Offset wraps inside the song region; the song bits never change.
                    if (note_end) begin
                        rom_addr_d = {rom_addr_q[ADDR_W-1 -: SONG_W],
                                      rom_addr_q[OFF_W-1:0] + OFF_W'(1)};
                    end
                end
`ifdef SONG_LOOP_EN
                S_END: rom_addr_d = {rom_addr_q[ADDR_W-1 -: SONG_W], {OFF_W{1'b0}}};
`endif
                default: rom_addr_d = rom_addr_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            tempo_q    <= '0;
            rest_q     <= 1'b1;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            div_q      <= DIV_W'(2);
            cnt0_q     <= '0;
            beat_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            tempo_q    <= tempo_d;
            rest_q     <= rest_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            div_q      <= div_d;
            cnt0_q     <= cnt0_d;
            beat_cnt_q <= beat_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

endmodule

// File: tb/tb_playsongs_seq.sv
// tb/tb_playsongs_seq.sv - scoreboard bench for playsongs_seq with a short-beat and a long-beat instance.
module tb_playsongs_seq;
`ifdef SONG_LOOP_EN
    localparam int LOOP = 1;
`else
    localparam int LOOP = 0;
`endif
    localparam int SIG_BUSY = 0;
    localparam int SIG_DONE = 1;
    localparam int SIG_ADDR = 2;
    localparam int SIG_BUZ  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s, stop_s, buz_s, busy_s, done_s;
    logic [1:0] sel_s, tempo_s;
    logic [7:0] addr_s, data_s;
    logic       start_l, stop_l, buz_l, busy_l, done_l;
    logic [1:0] sel_l, tempo_l;
    logic [7:0] addr_l, data_l;
    logic [7:0] rom_s [256];
    logic [7:0] rom_l [256];

    always @(posedge clk) data_s <= rom_s[addr_s];
    always @(posedge clk) data_l <= rom_l[addr_l];

    playsongs_seq #(.DIV_W(17), .ADDR_W(8), .SONG_W(2), .BEAT_CYCLES(64), .BEAT_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .stop(stop_s), .song_sel(sel_s), .tempo(tempo_s),
        .rom_addr(addr_s), .rom_data(data_s), .buzzer(buz_s), .busy(busy_s), .done(done_s)
    );

    playsongs_seq #(.DIV_W(17), .ADDR_W(8), .SONG_W(2), .BEAT_CYCLES(65536), .BEAT_W(17)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .stop(stop_l), .song_sel(sel_l), .tempo(tempo_l),
        .rom_addr(addr_l), .rom_data(data_l), .buzzer(buz_l), .busy(busy_l), .done(done_l)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        int    cyc;
        string tag;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int c, input string tag, input int sig, input int val);
        exp_t e;
        int   i;
        e.cyc = c;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    function automatic int observe(input int sig);
        case (sig)
            SIG_BUSY: return int'(busy_s);
            SIG_DONE: return int'(done_s);
            SIG_ADDR: return int'(addr_s);
            default:  return int'(buz_s);
        endcase
    endfunction

    int buz_cnt_s = 0;
    int done_cnt_s = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (buz_s) buz_cnt_s <= buz_cnt_s + 1;
        if (done_s) done_cnt_s <= done_cnt_s + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc == cyc) chk(e.tag, observe(e.sig), e.val);
            else chk({e.tag, "_cyc"}, cyc, e.cyc);
        end
    end

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("sb_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_start_s(input int sel, input int tmp, output int s);
        @(posedge clk);
        #1;
        sel_s   = sel[1:0];
        tempo_s = tmp[1:0];
        start_s = 1'b1;
        s = cyc;
    endtask

    task automatic end_start_s();
        @(posedge clk);
        #1;
        start_s = 1'b0;
    endtask

    task automatic stop_pulse_s();
        @(posedge clk);
        #1;
        stop_s = 1'b1;
        @(posedge clk);
        #1;
        stop_s = 1'b0;
    endtask

    task automatic start_l_song(input int sel, input int tmp, output int s);
        @(posedge clk);
        #1;
        sel_l   = sel[1:0];
        tempo_l = tmp[1:0];
        start_l = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start_l = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, t, b0, d0, n, r1, f1, r2, fh, lh, hc, dn;
        logic prev;
        rst = 1'b1;
        start_s = 1'b0; stop_s = 1'b0; sel_s = '0; tempo_s = '0;
        start_l = 1'b0; stop_l = 1'b0; sel_l = '0; tempo_l = '0;
        for (int i = 0; i < 256; i++) begin
            rom_s[i] = 8'hF0;
            rom_l[i] = 8'hF0;
        end
        rom_s[0] = 8'h10;
        rom_s[64] = 8'h02;
        rom_s[128] = 8'h01;
        for (int i = 192; i < 256; i++) rom_s[i] = 8'h00;
        rom_l[0] = 8'h90;
        rom_l[64] = 8'hE0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_s", busy_s, 0);
        chk("rst_done_s", done_s, 0);
        chk("rst_buz_s", buz_s, 0);
        chk("rst_addr_s", addr_s, 0);
        chk("rst_busy_l", busy_l, 0);
        chk("rst_done_l", done_l, 0);
        chk("rst_buz_l", buz_l, 0);
        chk("rst_addr_l", addr_l, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // song0 {0x10, 0xF0}: single beat then end marker
        begin_start_s(0, 0, s);
        b0 = buz_cnt_s; d0 = done_cnt_s;
        expect_at(s, "t1_busy_r0", SIG_BUSY, 0);
        expect_at(s + 1, "t1_addr_r1", SIG_ADDR, 0);
        expect_at(s + 1, "t1_busy_r1", SIG_BUSY, 1);
        expect_at(s + 2, "t1_busy_r2", SIG_BUSY, 1);
        expect_at(s + 66, "t1_addr_r66", SIG_ADDR, 0);
        expect_at(s + 67, "t1_addr_r67", SIG_ADDR, 1);
        expect_at(s + 68, "t1_done_r68", SIG_DONE, 0);
        expect_at(s + 69, "t1_done_r69", SIG_DONE, 1);
        expect_at(s + 70, "t1_done_r70", SIG_DONE, 0);
        expect_at(s + 70, "t1_busy_r70", SIG_BUSY, LOOP);
        expect_at(s + 70, "t1_addr_r70", SIG_ADDR, 1 - LOOP);
        expect_at(s + 138, "t1_done_r138", SIG_DONE, LOOP);
        end_start_s();
        wait_sb(200);
        chk("t1_buzz_quiet", buz_cnt_s - b0, 0);
        chk("t1_done_count", done_cnt_s - d0, 1 + LOOP);
        stop_pulse_s();

        // song1 {0x02, 0xF0}: three-beat rest
        begin_start_s(1, 0, s);
        b0 = buz_cnt_s;
        expect_at(s + 1, "t2_addr_r1", SIG_ADDR, 64);
        expect_at(s + 194, "t2_addr_r194", SIG_ADDR, 64);
        expect_at(s + 195, "t2_addr_r195", SIG_ADDR, 65);
        expect_at(s + 196, "t2_done_r196", SIG_DONE, 0);
        expect_at(s + 197, "t2_done_r197", SIG_DONE, 1);
        expect_at(s + 198, "t2_busy_r198", SIG_BUSY, LOOP);
        end_start_s();
        wait_sb(300);
        chk("t2_rest_quiet", buz_cnt_s - b0, 0);
        stop_pulse_s();

        // song2 {0x01, 0xF0} at tempo 1: two half-length beats
        begin_start_s(2, 1, s);
        expect_at(s + 1, "t3_addr_r1", SIG_ADDR, 128);
        expect_at(s + 66, "t3_addr_r66", SIG_ADDR, 128);
        expect_at(s + 67, "t3_addr_r67", SIG_ADDR, 129);
        expect_at(s + 68, "t3_done_r68", SIG_DONE, 0);
        expect_at(s + 69, "t3_done_r69", SIG_DONE, 1);
        end_start_s();
        wait_sb(100);
        stop_pulse_s();

        // song3 is 64 rests without an end marker: address wraps inside the region
        begin_start_s(3, 3, s);
        d0 = done_cnt_s;
        expect_at(s + 1, "t4_addr_r1", SIG_ADDR, 192);
        expect_at(s + 11, "t4_addr_r11", SIG_ADDR, 193);
        expect_at(s + 631, "t4_addr_r631", SIG_ADDR, 255);
        expect_at(s + 641, "t4_addr_wrap", SIG_ADDR, 192);
        expect_at(s + 642, "t4_busy_r642", SIG_BUSY, 1);
        end_start_s();
        wait_sb(800);
        stop_s = 1'b1;
        t = cyc;
        expect_at(t + 1, "t4_stop_busy", SIG_BUSY, 0);
        expect_at(t + 1, "t4_stop_buz", SIG_BUZ, 0);
        @(posedge clk);
        #1;
        stop_s = 1'b0;
        wait_sb(10);
        chk("t4_no_done", done_cnt_s - d0, 0);

        // start and stop together mid-note
        begin_start_s(0, 0, s);
        d0 = done_cnt_s;
        end_start_s();
        to_cycle(s + 20);
        start_s = 1'b1; stop_s = 1'b1; sel_s = 2'd1;
        t = cyc;
        expect_at(t + 1, "t5_busy", SIG_BUSY, 0);
        expect_at(t + 1, "t5_buz", SIG_BUZ, 0);
        expect_at(t + 1, "t5_done", SIG_DONE, 0);
        expect_at(t + 100, "t5_busy_later", SIG_BUSY, 0);
        @(posedge clk);
        #1;
        start_s = 1'b0; stop_s = 1'b0;
        wait_sb(150);
        chk("t5_no_done", done_cnt_s - d0, 0);

        // restart into song2 mid-song0
        begin_start_s(0, 0, s);
        d0 = done_cnt_s;
        end_start_s();
        to_cycle(s + 30);
        start_s = 1'b1; sel_s = 2'd2; tempo_s = 2'd0;
        s2 = cyc;
        expect_at(s2 + 1, "t6_addr_new", SIG_ADDR, 128);
        expect_at(s2 + 1, "t6_busy", SIG_BUSY, 1);
        expect_at(s + 69, "t6_old_done", SIG_DONE, 0);
        expect_at(s2 + 130, "t6_addr_r130", SIG_ADDR, 128);
        expect_at(s2 + 131, "t6_addr_r131", SIG_ADDR, 129);
        expect_at(s2 + 133, "t6_done", SIG_DONE, 1);
        expect_at(s2 + 134, "t6_busy_end", SIG_BUSY, LOOP);
        @(posedge clk);
        #1;
        start_s = 1'b0;
        wait_sb(250);
        chk("t6_done_count", done_cnt_s - d0, 1);
        stop_pulse_s();

        // reset mid-note
        begin_start_s(1, 0, s);
        end_start_s();
        to_cycle(s + 10);
        rst = 1'b1;
        t = cyc;
        expect_at(t + 1, "t7_busy", SIG_BUSY, 0);
        expect_at(t + 1, "t7_addr", SIG_ADDR, 0);
        expect_at(t + 1, "t7_buz", SIG_BUZ, 0);
        expect_at(t + 1, "t7_done", SIG_DONE, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sb(10);

        // 0x90: octave-up do, divider 22935
        start_l_song(0, 0, s);
        r1 = -1; f1 = -1; r2 = -1; n = 0; prev = 1'b0;
        while (r2 < 0 && n < 40000) begin
            @(negedge clk);
            n++;
            if (buz_l && !prev) begin
                if (r1 < 0) r1 = cyc;
                else r2 = cyc;
            end
            if (!buz_l && prev && r1 >= 0 && f1 < 0) f1 = cyc;
            prev = buz_l;
        end
        chk("l1_first_rise", r1 - s, 11471);
        chk("l1_high_time", f1 - r1, 11468);
        chk("l1_period", r2 - r1, 22935);
        @(posedge clk);
        #1;
        stop_l = 1'b1;
        @(posedge clk);
        #1;
        stop_l = 1'b0;

        // 0xE0 at tempo 3: tone cut by the articulation gap
        start_l_song(1, 3, s);
        fh = -1; lh = -1; hc = 0; dn = -1; n = 0;
        while (dn < 0 && n < 9000) begin
            @(negedge clk);
            n++;
            if (buz_l) begin
                hc++;
                if (fh < 0) fh = cyc;
                lh = cyc;
            end
            if (done_l) dn = cyc;
        end
        chk("l2_first_high", fh - s, 6822);
        chk("l2_last_high", lh - s, 7171);
        chk("l2_high_count", hc, 350);
        chk("l2_done_at", dn - s, 8197);
        @(negedge clk);
        chk("l2_busy_after", busy_l, LOOP);
        @(posedge clk);
        #1;
        stop_l = 1'b1;
        @(posedge clk);
        #1;
        stop_l = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
